hazard_detection_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 13 +
 rtl/div_stall_timer.sv | 46 ++++
 rtl/hazard_detection_unit.sv | 84 ++++++++
 tb/tb_hazard_detection_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the pipeline interlock controller.
//   - divide-FSM state encoding (RUN / DIV_WAIT)
//   - default divide latency
//   - architectural zero register number
package hazard_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_DIV_WAIT = 1'b1;

    localparam int         DIV_CYCLES_DEF = 8;
    localparam logic [4:0] REG_ZERO       = 5'd0;

endpackage

// File: rtl/div_stall_timer.sv
// div_stall_timer: tracks a multi-cycle divide occupying EX.
// Ports:
//   clk, rst_n    - pipeline clock, asynchronous active-low reset
//   Div_Start_EX  - instruction in ID/EX is a divide (ignored while waiting)
//   hold          - freeze the front of the pipeline this cycle
//   Div_Done      - divide result valid on EX output this cycle
module div_stall_timer
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Div_Start_EX,
    output logic hold,
    output logic Div_Done
);

    logic [0:0] r_state;
    logic [7:0] r_div_cnt;

    // The start cycle itself is the first hold cycle, so the counter only
    // has to cover DIV_CYCLES-2 further holds before the done cycle.
    localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 2);

    assign hold     = (r_state == ST_RUN && Div_Start_EX) ||
                      (r_state == ST_DIV_WAIT && r_div_cnt != 8'd0);
    assign Div_Done = (r_state == ST_DIV_WAIT) && (r_div_cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_div_cnt <= 8'd0;
        end else if (r_state == ST_RUN) begin
            if (Div_Start_EX) begin
                r_state   <= ST_DIV_WAIT;
                r_div_cnt <= CNT_INIT;
            end
        end else if (r_div_cnt != 8'd0) begin
            r_div_cnt <= r_div_cnt - 8'd1;
        end else begin
            r_state <= ST_RUN;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: stall/flush interlock for the 5-stage pipeline.
// Handles load-use stalls, taken-branch fetch kill and multi-cycle divide
// freeze; keeps a saturating count of cycles with PC_Write=0.
// Build option: define DIV_STALL_EN to generate the divide FSM; without it
// Div_Start_EX is ignored and Div_Done is tied low.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   MemRead_ID_EX, Rt_ID_EX          load in EX and its destination
//   Rs_IF_ID, Rt_IF_ID, UseRt_IF_ID  sources of the ID instruction
//   Branch_Taken_ID                  branch in ID resolved taken
//   Div_Start_EX                     divide in ID/EX
//   PC_Write, IF_ID_Write, ID_EX_Write       register update enables
//   ID_EX_Bubble, IF_ID_Flush, EX_MEM_Bubble bubble / flush controls
//   Div_Done                         divide result valid this cycle
//   Stall_Count                      saturating stall-cycle counter
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   MemRead_ID_EX,
    input  logic [4:0]             Rt_ID_EX,
    input  logic [4:0]             Rs_IF_ID,
    input  logic [4:0]             Rt_IF_ID,
    input  logic                   UseRt_IF_ID,
    input  logic                   Branch_Taken_ID,
    input  logic                   Div_Start_EX,
    output logic                   PC_Write,
    output logic                   IF_ID_Write,
    output logic                   ID_EX_Write,
    output logic                   ID_EX_Bubble,
    output logic                   IF_ID_Flush,
    output logic                   EX_MEM_Bubble,
    output logic                   Div_Done,
    output logic [STALL_CNT_W-1:0] Stall_Count
);

    logic w_hold_raw, w_done_raw;
    logic w_hold, w_load_use, w_flush;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

`ifdef DIV_STALL_EN
    div_stall_timer #(.DIV_CYCLES(DIV_CYCLES)) u_div_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .Div_Start_EX (Div_Start_EX),
        .hold         (w_hold_raw),
        .Div_Done     (w_done_raw)
    );
`else
    logic w_unused_div;
    assign w_unused_div = Div_Start_EX | (DIV_CYCLES < 2);
    assign w_hold_raw   = 1'b0;
    assign w_done_raw   = 1'b0;
`endif

    // Outputs are combinational, so gate everything with rst_n to present
    // the idle pattern while reset is held regardless of the inputs.
    assign w_hold     = rst_n & w_hold_raw;
    assign w_load_use = rst_n & ~w_hold & MemRead_ID_EX & (Rt_ID_EX != REG_ZERO) &
                        ((Rt_ID_EX == Rs_IF_ID) || (UseRt_IF_ID && Rt_ID_EX == Rt_IF_ID));
    // A suppressed flush is safe: ID is frozen, so the branch resolves again.
    assign w_flush    = rst_n & ~w_hold & ~w_load_use & Branch_Taken_ID;

    assign PC_Write      = ~(w_hold | w_load_use);
    assign IF_ID_Write   = ~(w_hold | w_load_use);
    assign ID_EX_Write   = ~w_hold;
    assign ID_EX_Bubble  = w_load_use;
    assign IF_ID_Flush   = w_flush;
    assign EX_MEM_Bubble = w_hold;
    assign Div_Done      = rst_n & w_done_raw;
    assign Stall_Count   = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (!PC_Write && r_stall_cnt != {STALL_CNT_W{1'b1}})
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mr, ut, br, dv;
    logic [4:0] rt_ex, rs, rt;

    logic pcw, ifw, idw, idb, fl, exb, dn;
    logic [15:0] cnt;
    logic pcw2, ifw2, idw2, idb2, fl2, exb2, dn2;
    logic [3:0] cnt2;

    int checks = 0;
    int errors = 0;

    // control bundle order: {PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble,
    //                        IF_ID_Flush, EX_MEM_Bubble, Div_Done}
    localparam logic [6:0] C_DEF  = 7'b1110000;
    localparam logic [6:0] C_LU   = 7'b0011000;
    localparam logic [6:0] C_FL   = 7'b1110100;
    localparam logic [6:0] C_HOLD = 7'b0000010;
    localparam logic [6:0] C_DONE = 7'b1110001;

    always #5 clk = ~clk;

    hazard_detection_unit #(.DIV_CYCLES(8), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead_ID_EX(mr), .Rt_ID_EX(rt_ex),
        .Rs_IF_ID(rs), .Rt_IF_ID(rt), .UseRt_IF_ID(ut), .Branch_Taken_ID(br),
        .Div_Start_EX(dv), .PC_Write(pcw), .IF_ID_Write(ifw), .ID_EX_Write(idw),
        .ID_EX_Bubble(idb), .IF_ID_Flush(fl), .EX_MEM_Bubble(exb),
        .Div_Done(dn), .Stall_Count(cnt)
    );

    hazard_detection_unit #(.DIV_CYCLES(2), .STALL_CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .MemRead_ID_EX(mr), .Rt_ID_EX(rt_ex),
        .Rs_IF_ID(rs), .Rt_IF_ID(rt), .UseRt_IF_ID(ut), .Branch_Taken_ID(br),
        .Div_Start_EX(dv), .PC_Write(pcw2), .IF_ID_Write(ifw2), .ID_EX_Write(idw2),
        .ID_EX_Bubble(idb2), .IF_ID_Flush(fl2), .EX_MEM_Bubble(exb2),
        .Div_Done(dn2), .Stall_Count(cnt2)
    );

    typedef struct {
        logic       mr;
        logic [4:0] rt_ex, rs, rt;
        logic       ut, br;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [6:0] ctl1();
        return {pcw, ifw, idw, idb, fl, exb, dn};
    endfunction

    function automatic logic [6:0] ctl2();
        return {pcw2, ifw2, idw2, idb2, fl2, exb2, dn2};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        mr = 0; rt_ex = 0; rs = 0; rt = 0; ut = 0; br = 0; dv = 0;
    endtask

    task automatic lu();
        mr = 1; rt_ex = 5'd8; rs = 5'd8;
    endtask

    task automatic do_reset();
        cyc();
        clr();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    initial begin
        tbl[0] = '{0, 0, 0, 0, 0, 0, C_DEF, "idle"};
        tbl[1] = '{1, 8, 8, 0, 0, 0, C_LU,  "lu_rs"};
        tbl[2] = '{1, 0, 0, 0, 1, 0, C_DEF, "load_r0"};
        tbl[3] = '{1, 9, 3, 9, 0, 0, C_DEF, "rt_unused"};
        tbl[4] = '{1, 9, 3, 9, 1, 0, C_LU,  "lu_rt"};
        tbl[5] = '{0, 9, 9, 9, 1, 0, C_DEF, "no_load"};
        tbl[6] = '{0, 0, 0, 0, 0, 1, C_FL,  "branch"};
        tbl[7] = '{1, 8, 2, 8, 1, 1, C_LU,  "lu_br"};
        tbl[8] = '{1, 31, 31, 0, 0, 0, C_LU, "lu_r31"};
        tbl[9] = '{1, 5, 4, 6, 1, 1, C_FL,  "miss_br"};

        // reset held with hazard-causing inputs: outputs must stay idle
        clr();
        rst_n = 0;
        lu(); br = 1; dv = 1;
        #3;
        chk("reset_ctl", 16'(ctl1()), 16'(C_DEF));
        chk("reset_cnt", cnt, 16'd0);
        #1;
        clr();
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            cyc();
            mr = tbl[i].mr; rt_ex = tbl[i].rt_ex; rs = tbl[i].rs;
            rt = tbl[i].rt; ut = tbl[i].ut; br = tbl[i].br; dv = 0;
            #3;
            chk(tbl[i].name, 16'(ctl1()), 16'(tbl[i].exp));
        end

        // single load-use costs one cycle, then the bubble cannot re-fire
        do_reset();
        cyc(); lu(); br = 1; #3;
        chk("lu1_ctl", 16'(ctl1()), 16'(C_LU));
        cyc(); mr = 0; #3;
        chk("lu1_next_flush", 16'(ctl1()), 16'(C_FL));
        chk("lu1_cnt", cnt, 16'd1);

        // divide, with a load-use + branch hidden under the hold, then a
        // back-to-back second divide
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            cyc();
            clr();
            dv = (k <= 16);
            if (k == 2) begin lu(); br = 1; end
            #3;
`ifdef DIV_STALL_EN
            chk($sformatf("div_c%0d", k), 16'(ctl1()),
                16'((k == 17) ? C_DEF : (k == 8 || k == 16) ? C_DONE : C_HOLD));
            if (k == 8)  chk("div_cnt1", cnt, 16'd7);
            if (k == 17) chk("div_cnt2", cnt, 16'd14);
`else
            chk($sformatf("nodiv_c%0d", k), 16'(ctl1()), 16'((k == 2) ? C_LU : C_DEF));
            if (k == 17) chk("nodiv_cnt", cnt, 16'd1);
`endif
        end

        // DIV_CYCLES=2: one hold cycle, the next cycle is the done cycle
        do_reset();
        cyc(); dv = 1; #3;
`ifdef DIV_STALL_EN
        chk("d2_hold", 16'(ctl2()), 16'(C_HOLD));
        cyc(); #3;
        chk("d2_done", 16'(ctl2()), 16'(C_DONE));
        cyc(); dv = 0; #3;
        chk("d2_idle", 16'(ctl2()), 16'(C_DEF));
        chk("d2_cnt", 16'(cnt2), 16'd1);
`else
        chk("d2_nodiv", 16'(ctl2()), 16'(C_DEF));
        cyc(); #3;
        chk("d2_nodiv_cnt", 16'(cnt2), 16'd0);
`endif

        // reset in the third divide cycle: immediate idle, no Div_Done later
        do_reset();
        cyc(); dv = 1;
        cyc();
        cyc();
        #2;
        rst_n = 0;
        #1;
        chk("rstdiv_ctl", 16'(ctl1()), 16'(C_DEF));
        chk("rstdiv_cnt", cnt, 16'd0);
        #1;
        dv = 0;
        rst_n = 1;
        for (int k = 0; k < 9; k++) begin
            cyc(); #3;
            chk($sformatf("rstdiv_after%0d", k), 16'(ctl1()), 16'(C_DEF));
        end

        // saturation of the 4-bit counter on dut2 vs 16-bit on dut
        do_reset();
        cyc(); lu();
        repeat (19) cyc();
        cyc(); clr(); #3;
        chk("sat_cnt4", 16'(cnt2), 16'd15);
        chk("sat_cnt16", cnt, 16'd20);
        cyc(); #3;
        chk("sat_hold4", 16'(cnt2), 16'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
